// File: rtl/prog_ctr_fetch_if.sv
// Fetch-stage bus between the decoder/bench side and the program-counter sequencer.
// Ports (slave = sequencer side):
//   in : Start, Stall, Jump, BranchEn, Halt, Target[PC_W], Offset[OFF_W]
//   out: ProgCtr[PC_W], Fetch, Running, Done, InstrCount[CNT_W]
interface prog_ctr_fetch_if #(
   parameter int unsigned PC_W  = 10,
   parameter int unsigned OFF_W = 8,
   parameter int unsigned CNT_W = 16
) ();
   logic             Start;
   logic             Stall;
   logic             Jump;
   logic             BranchEn;
   logic             Halt;
   logic [PC_W-1:0]  Target;
   logic [OFF_W-1:0] Offset;
   logic [PC_W-1:0]  ProgCtr;
   logic             Fetch;
   logic             Running;
   logic             Done;
   logic [CNT_W-1:0] InstrCount;

   modport master (
      output Start, Stall, Jump, BranchEn, Halt, Target, Offset,
      input  ProgCtr, Fetch, Running, Done, InstrCount
   );

   modport slave (
      input  Start, Stall, Jump, BranchEn, Halt, Target, Offset,
      output ProgCtr, Fetch, Running, Done, InstrCount
   );
endinterface

// File: rtl/prog_ctr_fetch.sv
// Fetch-stage program counter and IDLE/RUN/DONE run-control sequencer.
// Ports:
//   Clk   : single rising-edge clock
//   Reset : synchronous active-low reset
//   bus   : prog_ctr_fetch_if.slave (run control, decoder flags, PC and status out)
// ProgCtr, Running, Done and InstrCount are registered; Fetch is combinational.
module prog_ctr_fetch #(
   parameter int unsigned PC_W     = 10,
   parameter int unsigned OFF_W    = 8,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned RESET_PC = 0
) (
   input logic              Clk,
   input logic              Reset,
   prog_ctr_fetch_if.slave  bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [PC_W-1:0]  PC_START = PC_W'(RESET_PC);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0]       state, state_nxt;
   logic [PC_W-1:0]  pc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [PC_W-1:0]  branch_pc;

   // Signed offset widened to PC_W; the add wraps modulo 2^PC_W.
   assign branch_pc = bus.ProgCtr + PC_W'($signed(bus.Offset));

   // Next-state / next-PC / next-count selection.
   always_comb begin
      state_nxt = state;
      pc_nxt    = bus.ProgCtr;
      cnt_nxt   = bus.InstrCount;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (bus.Start) begin
               state_nxt = ST_RUN;
               pc_nxt    = PC_START;
               cnt_nxt   = '0;
            end
         end
         ST_RUN: begin
            if (!bus.Stall) begin
               // Halt cycle still retires, so the count steps before the PC choice.
               if (bus.InstrCount != CNT_MAX) begin
                  cnt_nxt = bus.InstrCount + CNT_W'(1);
               end
               if (bus.Halt) begin
                  state_nxt = ST_DONE;
               end else if (bus.Jump) begin
                  pc_nxt = bus.Target;
               end else if (bus.BranchEn) begin
                  pc_nxt = branch_pc;
               end else begin
                  pc_nxt = bus.ProgCtr + PC_W'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            pc_nxt    = PC_START;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and output registers; status flags registered from the next state.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state          <= ST_IDLE;
         bus.ProgCtr    <= PC_START;
         bus.InstrCount <= '0;
         bus.Running    <= 1'b0;
         bus.Done       <= 1'b0;
      end else begin
         state          <= state_nxt;
         bus.ProgCtr    <= pc_nxt;
         bus.InstrCount <= cnt_nxt;
         bus.Running    <= (state_nxt == ST_RUN);
         bus.Done       <= (state_nxt == ST_DONE);
      end
   end

   assign bus.Fetch = bus.Running & ~bus.Stall;
endmodule

// File: tb/tb_prog_ctr_fetch.sv
// Scoreboard bench for prog_ctr_fetch: a driver applies directed and random
// cycles, a behavioural model pushes the expected post-edge outputs, and
// independent monitors pop and compare.
module tb_prog_ctr_fetch;
   localparam int unsigned PC_W    = 10;
   localparam int unsigned OFF_W   = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int          PC_MOD  = 1 << PC_W;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   typedef struct {
      int pc;
      bit run;
      bit done;
      int cnt;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;

   prog_ctr_fetch_if #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W)) bus ();

   prog_ctr_fetch #(.PC_W(PC_W), .OFF_W(OFF_W), .CNT_W(CNT_W), .RESET_PC(0)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   exp_t exp_q[$];
   bit   fetch_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state (valid once the first reset has been applied).
   bit m_valid   = 1'b0;
   bit m_running = 1'b0;
   bit m_done    = 1'b0;
   int m_pc      = 0;
   int m_cnt     = 0;

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, $time, act, act, expv, expv);
      end
   endtask

   // One clock: drive inputs after the falling edge and record what the
   // model says the DUT must show after the next rising edge.
   task automatic step(input bit rst_n, input bit st, input bit sl, input bit jp,
                       input bit br, input bit hl, input int tgt, input int off);
      int soff;
      exp_t e;
      @(negedge Clk);
      Reset        = rst_n;
      bus.Start    = st;
      bus.Stall    = sl;
      bus.Jump     = jp;
      bus.BranchEn = br;
      bus.Halt     = hl;
      bus.Target   = PC_W'(tgt);
      bus.Offset   = OFF_W'(off);
      if (m_valid) fetch_q.push_back(m_running && !sl);
      soff = (off >= 128) ? off - 256 : off;
      if (!rst_n) begin
         m_valid   = 1'b1;
         m_running = 1'b0;
         m_done    = 1'b0;
         m_pc      = 0;
         m_cnt     = 0;
      end else if (m_valid) begin
         if (!m_running) begin
            if (st) begin
               m_running = 1'b1;
               m_done    = 1'b0;
               m_pc      = 0;
               m_cnt     = 0;
            end
         end else if (!sl) begin
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (hl) begin
               m_running = 1'b0;
               m_done    = 1'b1;
            end else if (jp) begin
               m_pc = tgt % PC_MOD;
            end else if (br) begin
               m_pc = (m_pc + soff + PC_MOD) % PC_MOD;
            end else begin
               m_pc = (m_pc + 1) % PC_MOD;
            end
         end
      end
      if (m_valid) begin
         e.pc   = m_pc;
         e.run  = m_running;
         e.done = m_done;
         e.cnt  = m_cnt;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle_step();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   // Registered-output monitor: compares just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ProgCtr",    int'(bus.ProgCtr),    e.pc);
            check("Running",    int'(bus.Running),    int'(e.run));
            check("Done",       int'(bus.Done),       int'(e.done));
            check("InstrCount", int'(bus.InstrCount), e.cnt);
         end
      end
   end

   // Combinational Fetch monitor: compares once the new inputs have settled.
   initial begin
      bit f;
      forever begin
         @(negedge Clk);
         #2;
         if (fetch_q.size() > 0) begin
            f = fetch_q.pop_front();
            check("Fetch", int'(bus.Fetch), int'(f));
         end
      end
   end

   initial begin
      Reset        = 1'b0;
      bus.Start    = 1'b0;
      bus.Stall    = 1'b0;
      bus.Jump     = 1'b0;
      bus.BranchEn = 1'b0;
      bus.Halt     = 1'b0;
      bus.Target   = '0;
      bus.Offset   = '0;

      // Reset, then start and run sequentially.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5, 0);
      idle_step();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (3) idle_step();
      // Jump and branch together at PC 3: jump wins; then branch by -2.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 'h200, 5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 'hFE);
      // Wrap forward at the top address, then backward via negative branch.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 'h3FF, 0);
      idle_step();
      idle_step();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 'hFD);
      // Zero-offset branch is a self-loop.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
      // Stall at PC 7 with Jump held, then release.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7, 0);
      repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 'h55, 0);
      idle_step();
      // Restart mid-run is ignored; fresh start from DONE happens below.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      repeat (10) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 'h123, 9);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (12) idle_step();
      // Halt at PC 12 after 12 retired, hold, then restart.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 'h77, 0);
      repeat (10) idle_step();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      // Run to PC 20, reset with Start and Stall high, then Start resumes.
      repeat (20) idle_step();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 'h99, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      repeat (4) idle_step();

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(63) != 0,
              $urandom_range(5) == 0,
              $urandom_range(3) == 0,
              $urandom_range(7) == 0,
              $urandom_range(5) == 0,
              $urandom_range(23) == 0,
              int'($urandom_range(PC_MOD - 1)),
              int'($urandom_range(255)));
      end

      repeat (3) @(negedge Clk);
      check("queue_drain", exp_q.size() + fetch_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prog_ctr_fetch.md
# prog_ctr_fetch

Fetch-stage program counter and run-control sequencer. It sits directly downstream of the control decoder and upstream of the instruction ROM. Each cycle it takes the decoder's `Jump` and `BranchEn` flags, a halt request, and a stall, and computes the next instruction address. It also owns the start/run/done handshake with the testbench and counts retired instructions.

## Interface
- `PC_W`, 10, program-counter / ROM address width
- `OFF_W`, 8, width of signed relative branch offset
- `CNT_W`, 16, width of retired-instruction counter
- `RESET_PC`, 0, start address loaded on reset and on every Start
---
- `Clk`  in  1  single clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-low reset, sampled on rising edge of `Clk`
- `Start`  in  1  begin/restart program execution (level, sampled each edge)
- `Stall`  in  1  freeze fetch this cycle
- `Jump`  in  1  absolute jump request from control decoder
- `BranchEn`  in  1  relative branch request from control decoder
- `Halt`  in  1  current instruction is the program-terminating halt
- `Target`  in  PC_W  absolute jump address (from target LUT)
- `Offset`  in  OFF_W  two's-complement relative branch offset
- `ProgCtr`  out  PC_W  current instruction address to ROM (registered)
- `Fetch`  out  1  ROM read enable = Running & ~Stall (combinational)
- `Running`  out  1  state == RUN (registered)
- `Done`  out  1  state == DONE (registered)
- `InstrCount`  out  CNT_W  retired instructions since last Start (registered)

## Operation
- FSM states: IDLE, RUN, DONE.
- **Reset** (`Reset`=0 at edge): state=IDLE, ProgCtr=RESET_PC, Running=0, Done=0, InstrCount=0. Reset overrides every other input.
- **IDLE**:
  - Holds all registers.
  - `Start`=1 → RUN, ProgCtr=RESET_PC, InstrCount=0.
- **RUN**, `Stall`=1: no register changes. Jump, BranchEn and Halt are ignored that cycle.
- **RUN**, `Stall`=0 — next-PC priority Halt > Jump > BranchEn > sequential:
  - Halt: → DONE, ProgCtr holds (points at halt instruction).
  - Jump: ProgCtr=Target.
  - BranchEn: ProgCtr = ProgCtr + sign_extend(Offset). Computed in PC_W bits, modulo 2^PC_W.
  - Otherwise: ProgCtr = ProgCtr + 1, modulo 2^PC_W (max address wraps to 0).
  - InstrCount increments by 1 on every non-stalled RUN cycle, including the halt cycle. It saturates at 2^CNT_W-1.
  - `Start` in RUN is ignored (no restart mid-program).
- **DONE**:
  - Holds ProgCtr and InstrCount so the bench can read them.
  - `Start`=1 → RUN, ProgCtr=RESET_PC, InstrCount=0, Done=0 on the same edge.
- Jump and BranchEn both asserted: Jump wins. Halt with either: Halt wins.
- Offset is always interpreted as signed. Offset=0 on a branch re-executes the same address (legal self-loop).

## Timing
- Instruction ROM read is combinational from ProgCtr. Decoder flags (Jump, BranchEn, Halt) are therefore valid in the same cycle as the ProgCtr that produced them. Next ProgCtr appears one cycle later (single-cycle fetch, no branch delay slot).
- Start sampled at edge k → Running=1 and ProgCtr=RESET_PC visible after edge k. The first instruction executes in cycle k+1.
- Halt sampled at edge k → Done=1, Running=0 after edge k. Fetch drops combinationally with Running.
- Stall affects only the edge at which it is high. Release resumes with no lost or duplicated address.
- Reset low mid-RUN at edge k → all outputs at reset values after edge k, regardless of Stall/Start.

## Test plan
- Reset then Start=1 for one cycle, no flags, 5 cycles → ProgCtr sequence 0,1,2,3,4,5; InstrCount=5; Running=1.
- At ProgCtr=3 assert Jump with Target=0x200 and BranchEn=1 together → next ProgCtr=0x200 (Jump priority). Then BranchEn with Offset=0xFE (-2) → 0x1FE.
- ProgCtr=0x3FF, sequential step → 0x000. Branch from 0x001 with Offset=0xFD (-3) → 0x3FE (wrap both directions).
- Stall held 3 cycles at ProgCtr=7 with Jump=1 asserted → ProgCtr stays 7, InstrCount unchanged. Release with no flags → 8.
- Halt at ProgCtr=12 after 12 retired → Done=1, Running=0, ProgCtr=12, InstrCount=13, held 10 cycles. Then Start → ProgCtr=0, InstrCount=0, Done=0.
- Reset low for one edge mid-RUN at ProgCtr=20 with Start=1 → ProgCtr=0, IDLE, all outputs 0. After Reset rises, Start still high → RUN from 0.
